// File: rtl/icache_dm_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
// Contents: FSM state encodings, boolean constants, instruction width and
// a saturating increment used by the optional hit/miss counters.
// Optional build macro: ICACHE_STAT_EN (statistics counters in icache_dm).
package icache_dm_pkg;

  localparam int INST_W = 32;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MISS = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [31:0] satInc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/icache_array.sv
// Storage for the direct-mapped instruction cache.
// Holds one valid bit, one tag and one 32-bit word per line. Reads are
// combinational, writes are synchronous, and only the valid bits are reset.
// Ports:
//   clk_i, rst_i   clock and synchronous active-high reset (valid bits only)
//   lookupPc_i     fetch address to look up
//   hit_o          line valid and tag matches lookupPc_i
//   rdData_o       data word stored at lookupPc_i's index
//   alignedPc_o    lookupPc_i with the byte offset cleared
//   wrEn_i         write the fill this edge (already qualified by rdy)
//   wrAddr_i       word-aligned address being filled
//   wrData_i       word being filled
module icache_array
  import icache_dm_pkg::*;
#(
  parameter int IDX_BITS = 6,
  parameter int ADDR_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] lookupPc_i,
  output logic              hit_o,
  output logic [INST_W-1:0] rdData_o,
  output logic [ADDR_W-1:0] alignedPc_o,
  input  logic              wrEn_i,
  input  logic [ADDR_W-1:0] wrAddr_i,
  input  logic [INST_W-1:0] wrData_i
);

  localparam int LINES = 2 ** IDX_BITS;
  localparam int TAG_W = ADDR_W - IDX_BITS - 2;

  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [INST_W-1:0]   data_q [LINES];

  logic [IDX_BITS-1:0] rdIdx;
  logic [TAG_W-1:0]    rdTag;
  logic [IDX_BITS-1:0] wrIdx;
  logic [TAG_W-1:0]    wrTag;
  logic [3:0]          unusedByteOffsets;

  // Split the lookup and fill addresses into line index and tag; the
  // byte offset inside the word plays no part in a word-per-line cache.
  always_comb begin
    rdIdx             = lookupPc_i[IDX_BITS+1:2];
    rdTag             = lookupPc_i[ADDR_W-1:IDX_BITS+2];
    wrIdx             = wrAddr_i[IDX_BITS+1:2];
    wrTag             = wrAddr_i[ADDR_W-1:IDX_BITS+2];
    alignedPc_o       = {lookupPc_i[ADDR_W-1:2], 2'b00};
    unusedByteOffsets = {lookupPc_i[1:0], wrAddr_i[1:0]};
  end

  // Hit compare and read data are purely combinational so a hit can be
  // registered into the response on the same edge the request is seen.
  always_comb begin
    hit_o    = valid_q[rdIdx] && (tag_q[rdIdx] == rdTag);
    rdData_o = data_q[rdIdx];
  end

  // Valid bits are the only reset storage; clearing them invalidates the
  // whole cache without touching the tag and data arrays.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (wrEn_i) begin
      valid_q[wrIdx] <= True;
    end
  end

  // Tag and data arrays take the fill with no reset so they map onto RAM.
  always_ff @(posedge clk_i) begin
    if (wrEn_i) begin
      tag_q[wrIdx]  <= wrTag;
      data_q[wrIdx] <= wrData_i;
    end
  end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped, one-word-per-line read-only instruction cache between the
// fetch unit and the memory controller's instruction port. Hits answer one
// cycle after the request; misses fetch a word over a level request /
// done-pulse handshake, fill the line, answer, then idle one cycle.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; low freezes every register
//   ifu_req, ifu_pc     fetch request (level) and address, taken in IDLE
//   ifu_clear           redirect; suppresses the pending response
//   ifu_valid, ifu_inst one-cycle response strobe and instruction
//   mc_req, mc_addr     request and word-aligned address to the controller
//   mc_data, mc_done    fetched word and its one-cycle completion pulse
//   stat_hit, stat_miss saturating counters (only with ICACHE_STAT_EN)
// Optional build macro: ICACHE_STAT_EN adds the hit/miss counters.
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int IDX_BITS = 6,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              ifu_req,
  input  logic [ADDR_W-1:0] ifu_pc,
  input  logic              ifu_clear,
  output logic              ifu_valid,
  output logic [31:0]       ifu_inst,
  output logic              mc_req,
  output logic [ADDR_W-1:0] mc_addr,
  input  logic [31:0]       mc_data,
  input  logic              mc_done
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0]       stat_hit,
  output logic [31:0]       stat_miss
`endif
);

  state_e              state_q, state_d;
  logic                drop_q, drop_d;
  logic                ifuValid_q, ifuValid_d;
  logic [INST_W-1:0]   ifuInst_q, ifuInst_d;
  logic [ADDR_W-1:0]   mcAddr_q, mcAddr_d;
  logic                fill;
  logic                hit;
  logic [INST_W-1:0]   rdData;
  logic [ADDR_W-1:0]   alignedPc;

  icache_array #(
    .IDX_BITS (IDX_BITS),
    .ADDR_W   (ADDR_W)
  ) u_array (
    .clk_i       (clk),
    .rst_i       (rst),
    .lookupPc_i  (ifu_pc),
    .hit_o       (hit),
    .rdData_o    (rdData),
    .alignedPc_o (alignedPc),
    .wrEn_i      (fill && rdy),
    .wrAddr_i    (mcAddr_q),
    .wrData_i    (mc_data)
  );

  // Next-state and response logic. A clear in IDLE only kills the response
  // due this edge; a clear during MISS is remembered in drop because the
  // controller cannot abort, so the fill still lands but is not answered.
  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    ifuValid_d = False;
    ifuInst_d  = ifuInst_q;
    mcAddr_d   = mcAddr_q;
    fill       = False;
    unique case (state_q)
      ST_IDLE: begin
        if (ifu_req) begin
          if (hit) begin
            ifuValid_d = !ifu_clear;
            if (!ifu_clear) begin
              ifuInst_d = rdData;
            end
          end else begin
            mcAddr_d = alignedPc;
            state_d  = ST_MISS;
          end
        end
      end
      ST_MISS: begin
        if (mc_done) begin
          fill       = True;
          ifuValid_d = !(drop_q || ifu_clear);
          if (!(drop_q || ifu_clear)) begin
            ifuInst_d = mc_data;
          end
          drop_d  = False;
          state_d = ST_DONE;
        end else if (ifu_clear) begin
          drop_d = True;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and response registers; rdy low holds everything, including
  // the request to the (equally frozen) memory controller.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      drop_q     <= False;
      ifuValid_q <= False;
      ifuInst_q  <= '0;
      mcAddr_q   <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      drop_q     <= drop_d;
      ifuValid_q <= ifuValid_d;
      ifuInst_q  <= ifuInst_d;
      mcAddr_q   <= mcAddr_d;
    end
  end

  assign ifu_valid = ifuValid_q;
  assign ifu_inst  = ifuInst_q;
  assign mc_req    = (state_q == ST_MISS);
  assign mc_addr   = mcAddr_q;

`ifdef ICACHE_STAT_EN
  logic [31:0] statHit_q;
  logic [31:0] statMiss_q;

  // Every request accepted in IDLE counts as exactly one hit or one miss,
  // whether or not a coincident clear suppresses its response.
  always_ff @(posedge clk) begin
    if (rst) begin
      statHit_q  <= '0;
      statMiss_q <= '0;
    end else if (rdy && (state_q == ST_IDLE) && ifu_req) begin
      if (hit) begin
        statHit_q <= satInc(statHit_q);
      end else begin
        statMiss_q <= satInc(statMiss_q);
      end
    end
  end

  assign stat_hit  = statHit_q;
  assign stat_miss = statMiss_q;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed self-checking bench for icache_dm (IDX_BITS=6, ADDR_W=32).
// Inputs change on the falling edge; outputs are read on the falling edge
// after the rising edge that produced them. Stat checks build only with
// ICACHE_STAT_EN.
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        ifu_req;
  logic [31:0] ifu_pc;
  logic        ifu_clear;
  logic        ifu_valid;
  logic [31:0] ifu_inst;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic [31:0] mc_data;
  logic        mc_done;
`ifdef ICACHE_STAT_EN
  logic [31:0] stat_hit;
  logic [31:0] stat_miss;
`endif

  int checks   = 0;
  int failures = 0;

  icache_dm #(.IDX_BITS(6), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .ifu_req   (ifu_req),
    .ifu_pc    (ifu_pc),
    .ifu_clear (ifu_clear),
    .ifu_valid (ifu_valid),
    .ifu_inst  (ifu_inst),
    .mc_req    (mc_req),
    .mc_addr   (mc_addr),
    .mc_data   (mc_data),
    .mc_done   (mc_done)
`ifdef ICACHE_STAT_EN
    ,
    .stat_hit  (stat_hit),
    .stat_miss (stat_miss)
`endif
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Drives a complete miss: request, lat cycles of mc_req, done pulse,
  // DONE cycle. Leaves the cache back in IDLE at a falling edge.
  task automatic run_miss(input logic [31:0] pc, input logic [31:0] data, input int lat);
    ifu_req = 1'b1;
    ifu_pc  = pc;
    tick();
    ifu_req = 1'b0;
    repeat (lat - 1) tick();
    mc_done = 1'b1;
    mc_data = data;
    tick();
    mc_done = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; ifu_req = 1'b0; ifu_pc = '0; ifu_clear = 1'b0;
    mc_data = '0; mc_done = 1'b0;
    tick(); tick();
    checks++; if (ifu_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", ifu_valid); end
    checks++; if (ifu_inst !== 32'h0) begin failures++; $display("[TB] FAIL reset_inst got=%h exp=00000000", ifu_inst); end
    checks++; if (mc_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_mc_req got=%b exp=0", mc_req); end
    checks++; if (mc_addr !== 32'h0) begin failures++; $display("[TB] FAIL reset_mc_addr got=%h exp=00000000", mc_addr); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_miss_fill();
    int reqCycles;
    reqCycles = 0;
    ifu_req = 1'b1; ifu_pc = 32'h0;
    tick();
    ifu_req = 1'b0;
    checks++; if (mc_addr !== 32'h0) begin failures++; $display("[TB] FAIL miss_addr got=%h exp=00000000", mc_addr); end
    checks++; if (ifu_valid !== 1'b0) begin failures++; $display("[TB] FAIL miss_no_resp got=%b exp=0", ifu_valid); end
    for (int i = 0; i < 5; i++) begin
      if (mc_req === 1'b1) reqCycles++;
      if (i == 4) begin mc_done = 1'b1; mc_data = 32'h0000_0013; end
      tick();
    end
    mc_done = 1'b0;
    checks++; if (reqCycles != 5) begin failures++; $display("[TB] FAIL miss_req_cycles got=%0d exp=5", reqCycles); end
    checks++; if (ifu_valid !== 1'b1) begin failures++; $display("[TB] FAIL fill_valid got=%b exp=1", ifu_valid); end
    checks++; if (ifu_inst !== 32'h13) begin failures++; $display("[TB] FAIL fill_inst got=%h exp=00000013", ifu_inst); end
    checks++; if (mc_req !== 1'b0) begin failures++; $display("[TB] FAIL done_mc_req got=%b exp=0", mc_req); end
    tick();
    checks++; if (ifu_valid !== 1'b0) begin failures++; $display("[TB] FAIL fill_pulse got=%b exp=0", ifu_valid); end
  endtask

  task automatic test_back_to_back();
    run_miss(32'h4, 32'hAAAA_0004, 2);
    ifu_req = 1'b1; ifu_pc = 32'h0;
    tick();
    checks++; if (ifu_valid !== 1'b1 || ifu_inst !== 32'h13) begin failures++; $display("[TB] FAIL b2b_first got=%b/%h exp=1/00000013", ifu_valid, ifu_inst); end
    ifu_pc = 32'h4;
    tick();
    checks++; if (ifu_valid !== 1'b1 || ifu_inst !== 32'hAAAA_0004) begin failures++; $display("[TB] FAIL b2b_second got=%b/%h exp=1/aaaa0004", ifu_valid, ifu_inst); end
    ifu_pc = 32'h7;
    tick();
    checks++; if (ifu_valid !== 1'b1 || ifu_inst !== 32'hAAAA_0004) begin failures++; $display("[TB] FAIL b2b_unaligned got=%b/%h exp=1/aaaa0004", ifu_valid, ifu_inst); end
    checks++; if (mc_req !== 1'b0) begin failures++; $display("[TB] FAIL b2b_mc_req got=%b exp=0", mc_req); end
    ifu_req = 1'b0;
    tick();
    checks++; if (ifu_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_end got=%b exp=0", ifu_valid); end
  endtask

  task automatic test_conflict();
    ifu_req = 1'b1; ifu_pc = 32'h100;
    tick();
    ifu_req = 1'b0;
    checks++; if (mc_req !== 1'b1 || mc_addr !== 32'h100) begin failures++; $display("[TB] FAIL conflict_miss got=%b/%h exp=1/00000100", mc_req, mc_addr); end
    tick();
    mc_done = 1'b1; mc_data = 32'hBEEF_0100;
    tick();
    mc_done = 1'b0;
    checks++; if (ifu_valid !== 1'b1 || ifu_inst !== 32'hBEEF_0100) begin failures++; $display("[TB] FAIL conflict_fill got=%b/%h exp=1/beef0100", ifu_valid, ifu_inst); end
    tick();
    ifu_req = 1'b1; ifu_pc = 32'h0;
    tick();
    ifu_req = 1'b0;
    checks++; if (mc_req !== 1'b1 || mc_addr !== 32'h0 || ifu_valid !== 1'b0) begin failures++; $display("[TB] FAIL conflict_evict got=%b/%h/%b exp=1/00000000/0", mc_req, mc_addr, ifu_valid); end
    mc_done = 1'b1; mc_data = 32'h0000_0013;
    tick();
    mc_done = 1'b0;
    checks++; if (ifu_valid !== 1'b1 || ifu_inst !== 32'h13) begin failures++; $display("[TB] FAIL conflict_refill got=%b/%h exp=1/00000013", ifu_valid, ifu_inst); end
    tick();
  endtask

  task automatic test_clear();
    ifu_req = 1'b1; ifu_pc = 32'h40;
    tick();
    ifu_req = 1'b0;
    tick();
    ifu_clear = 1'b1;
    tick();
    ifu_clear = 1'b0;
    checks++; if (mc_req !== 1'b1 || mc_addr !== 32'h40) begin failures++; $display("[TB] FAIL clear_req_held got=%b/%h exp=1/00000040", mc_req, mc_addr); end
    tick();
    mc_done = 1'b1; mc_data = 32'h4040_4040;
    tick();
    mc_done = 1'b0;
    checks++; if (ifu_valid !== 1'b0 || mc_req !== 1'b0) begin failures++; $display("[TB] FAIL clear_dropped got=%b/%b exp=0/0", ifu_valid, mc_req); end
    tick();
    ifu_req = 1'b1; ifu_pc = 32'h40;
    tick();
    ifu_req = 1'b0;
    checks++; if (ifu_valid !== 1'b1 || ifu_inst !== 32'h4040_4040 || mc_req !== 1'b0) begin failures++; $display("[TB] FAIL clear_fill_kept got=%b/%h/%b exp=1/40404040/0", ifu_valid, ifu_inst, mc_req); end
    ifu_req = 1'b1; ifu_pc = 32'h80;
    tick();
    ifu_req = 1'b0;
    mc_done = 1'b1; mc_data = 32'h8080_8080; ifu_clear = 1'b1;
    tick();
    mc_done = 1'b0; ifu_clear = 1'b0;
    checks++; if (ifu_valid !== 1'b0) begin failures++; $display("[TB] FAIL clear_with_done got=%b exp=0", ifu_valid); end
    tick();
    ifu_req = 1'b1; ifu_pc = 32'h80;
    tick();
    checks++; if (ifu_valid !== 1'b1 || ifu_inst !== 32'h8080_8080) begin failures++; $display("[TB] FAIL clear_done_fill got=%b/%h exp=1/80808080", ifu_valid, ifu_inst); end
    ifu_pc = 32'h0; ifu_clear = 1'b1;
    tick();
    ifu_clear = 1'b0;
    checks++; if (ifu_valid !== 1'b0) begin failures++; $display("[TB] FAIL clear_idle_hit got=%b exp=0", ifu_valid); end
    tick();
    ifu_req = 1'b0;
    checks++; if (ifu_valid !== 1'b1 || ifu_inst !== 32'h13) begin failures++; $display("[TB] FAIL clear_redirect got=%b/%h exp=1/00000013", ifu_valid, ifu_inst); end
    tick();
  endtask

  task automatic test_rdy();
    ifu_req = 1'b1; ifu_pc = 32'hC0;
    tick();
    ifu_req = 1'b0;
    tick();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (mc_req !== 1'b1 || mc_addr !== 32'hC0 || ifu_valid !== 1'b0) begin failures++; $display("[TB] FAIL rdy_miss_hold[%0d] got=%b/%h/%b exp=1/000000c0/0", i, mc_req, mc_addr, ifu_valid); end
    end
    rdy = 1'b1; mc_done = 1'b1; mc_data = 32'hC0C0_C0C0;
    tick();
    mc_done = 1'b0;
    checks++; if (ifu_valid !== 1'b1 || ifu_inst !== 32'hC0C0_C0C0) begin failures++; $display("[TB] FAIL rdy_fill got=%b/%h exp=1/c0c0c0c0", ifu_valid, ifu_inst); end
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ifu_valid !== 1'b1 || ifu_inst !== 32'hC0C0_C0C0 || mc_req !== 1'b0) begin failures++; $display("[TB] FAIL rdy_resp_hold[%0d] got=%b/%h/%b exp=1/c0c0c0c0/0", i, ifu_valid, ifu_inst, mc_req); end
    end
    rdy = 1'b1;
    tick();
    checks++; if (ifu_valid !== 1'b0) begin failures++; $display("[TB] FAIL rdy_no_dup got=%b exp=0", ifu_valid); end
    ifu_req = 1'b1; ifu_pc = 32'hC0; rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ifu_valid !== 1'b0) begin failures++; $display("[TB] FAIL rdy_hit_hold[%0d] got=%b exp=0", i, ifu_valid); end
    end
    rdy = 1'b1;
    tick();
    ifu_req = 1'b0;
    checks++; if (ifu_valid !== 1'b1 || ifu_inst !== 32'hC0C0_C0C0) begin failures++; $display("[TB] FAIL rdy_hit_resume got=%b/%h exp=1/c0c0c0c0", ifu_valid, ifu_inst); end
    tick();
    checks++; if (ifu_valid !== 1'b0) begin failures++; $display("[TB] FAIL rdy_hit_once got=%b exp=0", ifu_valid); end
  endtask

`ifdef ICACHE_STAT_EN
  task automatic test_stats();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (stat_hit !== 32'd0 || stat_miss !== 32'd0) begin failures++; $display("[TB] FAIL stat_reset got=%0d/%0d exp=0/0", stat_hit, stat_miss); end
    run_miss(32'h0, 32'h13, 2);
    run_miss(32'h4, 32'hAAAA_0004, 2);
    ifu_req = 1'b1; ifu_pc = 32'h0;
    tick();
    ifu_pc = 32'h4;
    tick();
    ifu_pc = 32'h0;
    tick();
    ifu_req = 1'b0;
    checks++; if (stat_hit !== 32'd3 || stat_miss !== 32'd2) begin failures++; $display("[TB] FAIL stat_counts got=%0d/%0d exp=3/2", stat_hit, stat_miss); end
    ifu_req = 1'b1; ifu_pc = 32'h200;
    tick();
    ifu_req = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (stat_hit !== 32'd0 || stat_miss !== 32'd0 || mc_req !== 1'b0) begin failures++; $display("[TB] FAIL stat_rst_mid_miss got=%0d/%0d/%b exp=0/0/0", stat_hit, stat_miss, mc_req); end
    tick();
  endtask
`endif

  initial begin
    $display("[TB] start");
    test_reset();
    test_miss_fill();
    test_back_to_back();
    test_conflict();
    test_clear();
    test_rdy();
`ifdef ICACHE_STAT_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
